// File: rtl/shift_reg_deserializer.sv
// Serial frame receiver: start bit, then WIDTH data bits MSB- or LSB-first,
// presented on a one-entry valid/ready buffer with a sticky overrun flag.
module shift_reg_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sen,
    input  logic             dir,
    input  logic             sclr,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    input  logic             dready,
    output logic             busy,
    output logic             ovr,
    input  logic             ovr_clr
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  sr_reg, sr_next, sr_shift;
    logic [CW-1:0]     count_reg, count_next;
    logic              dir_reg, dir_next;
    logic              post;
    logic [WIDTH-1:0]  dout_reg;
    logic              dvalid_reg;
    logic              ovr_reg;

    // Shifted word for the frame's latched direction: left inserts at bit 0, right at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign sr_shift[gi] = dir_reg ? sr_reg[1] : sin;
            end else if (gi == WIDTH - 1) begin : g_msb
                assign sr_shift[gi] = dir_reg ? sin : sr_reg[WIDTH-2];
            end else begin : g_mid
                assign sr_shift[gi] = dir_reg ? sr_reg[gi+1] : sr_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        count_next = count_reg;
        dir_next   = dir_reg;
        post       = 1'b0;
        if (sclr) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sen && sin) begin
                        dir_next   = dir;
                        count_next = '0;
                        state_next = RECV;
                    end
                end
                RECV: begin
                    if (sen) begin
                        sr_next    = sr_shift;
                        count_next = count_reg + CW'(1);
                        if (count_reg == CW'(WIDTH - 1)) begin
                            state_next = IDLE;
                            post       = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            count_reg <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            count_reg <= count_next;
            dir_reg   <= dir_next;
        end
    end

    // A post on the same edge as an accept replaces the word instead of overrunning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg   <= '0;
            dvalid_reg <= 1'b0;
            ovr_reg    <= 1'b0;
        end else begin
            if (post && (!dvalid_reg || dready)) begin
                dout_reg   <= sr_shift;
                dvalid_reg <= 1'b1;
            end else if (dvalid_reg && dready) begin
                dvalid_reg <= 1'b0;
            end
            if (post && dvalid_reg && !dready) begin
                ovr_reg <= 1'b1;
            end else if (ovr_clr) begin
                ovr_reg <= 1'b0;
            end
        end
    end

    assign dout   = dout_reg;
    assign dvalid = dvalid_reg;
    assign ovr    = ovr_reg;
    assign busy   = (state_reg == RECV);

endmodule
